// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Debounces Start/Stop and Lap/Reset buttons and sequences
//               run / clear / freeze / lap count for the stopwatch datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       run,
  output logic       clr_cnt,
  output logic       freeze,
  output logic [3:0] lap_cnt,
  output logic [1:0] state
);

  localparam logic [DB_W-1:0] c_DB_MAX  = DB_W'(DB_CYCLES - 1);
  localparam logic [3:0]      c_LAP_MAX = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {btn_lr, btn_ss};

  // Bit 0 conditions Start/Stop, bit 1 conditions Lap/Reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic            r_meta;
    logic            r_sync;
    logic            r_stb;
    logic            r_stb_d;
    logic [DB_W-1:0] r_dbc;

    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        r_meta  <= 1'b0;
        r_sync  <= 1'b0;
        r_stb   <= 1'b0;
        r_stb_d <= 1'b0;
        r_dbc   <= '0;
      end else begin
        r_meta  <= w_raw[gi];
        r_sync  <= r_meta;
        r_stb_d <= r_stb;
        // Any return to the stable level restarts the qualification window.
        if (r_sync != r_stb) begin
          if (r_dbc == c_DB_MAX) begin
            r_stb <= r_sync;
            r_dbc <= '0;
          end else begin
            r_dbc <= r_dbc + DB_W'(1);
          end
        end else begin
          r_dbc <= '0;
        end
      end
    end

    assign w_press[gi] = r_stb & ~r_stb_d;
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_clr_nxt;
  logic       w_lap_inc;
  logic       r_run;
  logic       r_freeze;
  logic       r_clr;
  logic [3:0] r_lap;
  logic       w_ss;
  logic       w_lr;

  assign w_ss = w_press[0];
  assign w_lr = w_press[1];

  // Start/Stop takes priority; a simultaneous Lap/Reset is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    w_lap_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss) begin
          w_state_nxt = S_RUN;
        end else if (w_lr) begin
          w_clr_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (w_ss) begin
          w_state_nxt = S_PAUSE;
        end else if (w_lr) begin
          w_state_nxt = S_LAP;
          w_lap_inc   = 1'b1;
        end
      end
      S_LAP: begin
        if (w_ss) begin
          w_state_nxt = S_PAUSE;
        end else if (w_lr) begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (w_ss) begin
          w_state_nxt = S_RUN;
        end else if (w_lr) begin
          w_state_nxt = S_IDLE;
          w_clr_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_IDLE;
      r_run    <= 1'b0;
      r_freeze <= 1'b0;
      r_clr    <= 1'b0;
      r_lap    <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
      r_freeze <= (w_state_nxt == S_LAP);
      r_clr    <= w_clr_nxt;
      if (w_clr_nxt) begin
        r_lap <= 4'd0;
      end else if (w_lap_inc && (r_lap != c_LAP_MAX)) begin
        r_lap <= r_lap + 4'd1;
      end
    end
  end

  assign run     = r_run;
  assign freeze  = r_freeze;
  assign clr_cnt = r_clr;
  assign lap_cnt = r_lap;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl (DB_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic       clk;
  logic       clear_n;
  logic       btn_ss;
  logic       btn_lr;
  logic       run;
  logic       clr_cnt;
  logic       freeze;
  logic [3:0] lap_cnt;
  logic [1:0] state;

  int n_vec;
  int n_err;
  int n_clr;
  int n_chg;

  stopwatch_ctrl #(
    .DB_CYCLES(4),
    .DB_W     (3)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .btn_ss (btn_ss),
    .btn_lr (btn_lr),
    .run    (run),
    .clr_cnt(clr_cnt),
    .freeze (freeze),
    .lap_cnt(lap_cnt),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the selected buttons for 8 cycles, release for 8; counts clr_cnt pulses.
  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        btn_ss = 1'b0;
        btn_lr = 1'b0;
      end
      tick(1);
      if (clr_cnt) begin
        n_clr++;
        chk("clr_in_idle", 16'(state), 16'd0);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    n_clr   = 0;
    clear_n = 1'b0;
    btn_ss  = 1'b0;
    btn_lr  = 1'b0;

    // 1. Reset values and idle stability
    tick(3);
    chk("rst_outputs", {7'd0, run, freeze, clr_cnt, lap_cnt, state}, 16'd0);
    clear_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_stable", {7'd0, run, freeze, clr_cnt, lap_cnt, state}, 16'd0);
    end

    // 2. Clean start with exact latency, then stop
    btn_ss = 1'b1;
    tick(6);
    chk("start_run_early", 16'(run), 16'd0);
    tick(1);
    chk("start_run", 16'(run), 16'd1);
    chk("start_state", 16'(state), 16'd1);
    tick(3);
    btn_ss = 1'b0;
    tick(8);
    press(1'b1, 1'b0);
    chk("stop_state", 16'(state), 16'd3);
    chk("stop_run", 16'(run), 16'd0);

    // 3. Bounce rejection from IDLE
    press(1'b0, 1'b1);
    chk("bounce_pre_idle", 16'(state), 16'd0);
    btn_ss = 1'b1; tick(1);
    btn_ss = 1'b0; tick(1);
    btn_ss = 1'b1; tick(1);
    btn_ss = 1'b0; tick(1);
    chk("bounce_glitch_state", 16'(state), 16'd0);
    btn_ss = 1'b1;
    n_chg = 0;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] prev;
      prev = state;
      tick(1);
      if (state != prev) n_chg++;
    end
    btn_ss = 1'b0;
    tick(8);
    chk("bounce_transitions", 16'(n_chg), 16'd1);
    chk("bounce_state", 16'(state), 16'd1);

    // 4. Laps and saturation
    press(1'b0, 1'b1);
    chk("lap1_state", 16'(state), 16'd2);
    chk("lap1_freeze", 16'(freeze), 16'd1);
    chk("lap1_run", 16'(run), 16'd1);
    press(1'b0, 1'b1);
    chk("lap2_state", 16'(state), 16'd1);
    chk("lap2_freeze", 16'(freeze), 16'd0);
    press(1'b0, 1'b1);
    chk("lap3_state", 16'(state), 16'd2);
    chk("lap3_freeze", 16'(freeze), 16'd1);
    chk("lap3_cnt", 16'(lap_cnt), 16'd2);
    for (int i = 0; i < 30; i++) press(1'b0, 1'b1);
    chk("lap_sat_cnt", 16'(lap_cnt), 16'd15);
    chk("lap_sat_state", 16'(state), 16'd2);

    // 5. Clear from PAUSE with lap_cnt=5, then clear again in IDLE
    press(1'b1, 1'b0);
    chk("lap_to_pause", 16'(state), 16'd3);
    chk("pause_freeze", 16'(freeze), 16'd0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("pre_clr_state", 16'(state), 16'd3);
    chk("pre_clr_lap", 16'(lap_cnt), 16'd5);
    n_clr = 0;
    press(1'b0, 1'b1);
    chk("clr_pulses", 16'(n_clr), 16'd1);
    chk("clr_state", 16'(state), 16'd0);
    chk("clr_lap", 16'(lap_cnt), 16'd0);
    n_clr = 0;
    press(1'b0, 1'b1);
    chk("idle_clr_pulses", 16'(n_clr), 16'd1);
    chk("idle_clr_state", 16'(state), 16'd0);

    // 6a. Simultaneous press in RUN: Start/Stop wins
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("pre_both_state", 16'(state), 16'd1);
    chk("pre_both_lap", 16'(lap_cnt), 16'd1);
    press(1'b1, 1'b1);
    chk("both_state", 16'(state), 16'd3);
    chk("both_lap", 16'(lap_cnt), 16'd1);

    // 6b. Reset mid-debounce, then a held button debounces afresh
    btn_ss = 1'b1;
    tick(2);
    clear_n = 1'b0;
    #1;
    chk("async_rst", {7'd0, run, freeze, clr_cnt, lap_cnt, state}, 16'd0);
    tick(2);
    clear_n = 1'b1;
    tick(6);
    chk("post_rst_run_early", 16'(run), 16'd0);
    tick(1);
    chk("post_rst_run", 16'(run), 16'd1);
    chk("post_rst_state", 16'(state), 16'd1);
    btn_ss = 1'b0;
    tick(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
